// File: rtl/morse_pkg.sv
// Shared token codes, FSM states and unit-count thresholds for the Morse element classifier.
package morse_pkg;

   typedef enum logic [1:0] {
      TOK_DOT      = 2'd0,
      TOK_DASH     = 2'd1,
      TOK_CHAR_GAP = 2'd2,
      TOK_WORD_GAP = 2'd3
   } tok_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_MARK,
      ST_SPACE,
      ST_CHAR_SP
   } cls_state_t;

   localparam logic [3:0] DASH_MIN_UNITS = 4'd2;
   localparam logic [3:0] CHAR_GAP_UNITS = 4'd2;
   localparam logic [3:0] WORD_GAP_UNITS = 4'd5;
   localparam logic [3:0] UNIT_CNT_MAX   = 4'd15;

   function automatic logic [3:0] unit_sat_inc(input logic [3:0] v);
      return (v == UNIT_CNT_MAX) ? v : v + 4'd1;
   endfunction

endpackage

// File: rtl/morse_tok_fifo.sv
// Two-entry token buffer: push side with full flag, pop side with valid/ready handshake.
module morse_tok_fifo (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       push,
   input  logic [1:0] push_data,
   output logic       full,
   output logic       pop_valid,
   output logic [1:0] pop_data,
   input  logic       pop_ready
);

   logic [1:0] mem [2];
   logic       wr_ptr;
   logic       rd_ptr;
   logic [1:0] count;
   logic       do_push;
   logic       do_pop;

   assign pop_valid = (count != 2'd0);
   assign full      = (count == 2'd2);
   assign do_pop    = pop_valid && pop_ready;
   // A pop in the same cycle frees the slot a full-buffer push needs.
   assign do_push   = push && (!full || do_pop);
   assign pop_data  = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem[0] <= 2'd0;
         mem[1] <= 2'd0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= ~wr_ptr;
         end
         if (do_pop) begin
            rd_ptr <= ~rd_ptr;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/morse_element_classifier.sv
// Measures mark/space runs on the keyed line in Morse units and emits DOT/DASH/gap tokens.
// Define MORSE_CLS_SYNC_EN for a 2-flop input synchronizer when the line is asynchronous.
module morse_element_classifier
   import morse_pkg::*;
#(
   parameter int UNIT_CYCLES = 1,
   parameter int CNT_W       = 8
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_data_morse,
   output logic       o_tok_valid,
   output logic [1:0] o_tok,
   input  logic       i_tok_ready,
   output logic       o_overflow
);

   localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(UNIT_CYCLES - 1);

   logic             line_s;
   logic             line_prev;
   logic             edge_det;
   logic [CNT_W-1:0] pre_cnt;
   logic [CNT_W-1:0] pre_base;
   logic [CNT_W-1:0] pre_nxt;
   logic [3:0]       unit_cnt;
   logic [3:0]       unit_base;
   logic [3:0]       unit_nxt;
   cls_state_t       state;
   cls_state_t       ret_state;
   logic             push_req;
   tok_t             push_tok;
   logic             fifo_full;
   logic             tok_pop;

`ifdef MORSE_CLS_SYNC_EN
   logic sync_meta;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sync_meta <= 1'b0;
         line_s    <= 1'b0;
      end else begin
         sync_meta <= i_data_morse;
         line_s    <= sync_meta;
      end
   end
`else
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         line_s <= 1'b0;
      end else begin
         line_s <= i_data_morse;
      end
   end
`endif

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         line_prev <= 1'b0;
      end else begin
         line_prev <= line_s;
      end
   end

   assign edge_det = line_s ^ line_prev;

   // The edge cycle itself is the first counted cycle of the new run, so a run of
   // exactly UNIT_CYCLES shows unit_cnt==1 on the cycle its closing edge appears.
   always_comb begin
      pre_base  = edge_det ? '0 : pre_cnt;
      unit_base = edge_det ? 4'd0 : unit_cnt;
      pre_nxt   = pre_base + CNT_W'(1);
      unit_nxt  = unit_base;
      if (pre_base == PRE_LAST) begin
         pre_nxt  = '0;
         unit_nxt = unit_sat_inc(unit_base);
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         pre_cnt  <= '0;
         unit_cnt <= 4'd0;
      end else begin
         pre_cnt  <= pre_nxt;
         unit_cnt <= unit_nxt;
      end
   end

   always_comb begin
      push_req = 1'b0;
      push_tok = TOK_DOT;
      case (state)
         ST_MARK: begin
            if (edge_det && (unit_cnt != 4'd0)) begin
               push_req = 1'b1;
               push_tok = (unit_cnt >= DASH_MIN_UNITS) ? TOK_DASH : TOK_DOT;
            end
         end
         ST_SPACE: begin
            if (unit_cnt >= CHAR_GAP_UNITS) begin
               push_req = 1'b1;
               push_tok = TOK_CHAR_GAP;
            end
         end
         ST_CHAR_SP: begin
            if (unit_cnt >= WORD_GAP_UNITS) begin
               push_req = 1'b1;
               push_tok = TOK_WORD_GAP;
            end
         end
         default: ;
      endcase
   end

   // ret_state remembers where a mark started so a sub-unit glitch can be undone.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state     <= ST_IDLE;
         ret_state <= ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: begin
               if (edge_det) begin
                  state     <= ST_MARK;
                  ret_state <= ST_IDLE;
               end
            end
            ST_MARK: begin
               if (edge_det) begin
                  state <= (unit_cnt == 4'd0) ? ret_state : ST_SPACE;
               end
            end
            ST_SPACE: begin
               if (edge_det) begin
                  state     <= ST_MARK;
                  ret_state <= (unit_cnt >= CHAR_GAP_UNITS) ? ST_CHAR_SP : ST_SPACE;
               end else if (unit_cnt >= CHAR_GAP_UNITS) begin
                  state <= ST_CHAR_SP;
               end
            end
            ST_CHAR_SP: begin
               if (edge_det) begin
                  state     <= ST_MARK;
                  ret_state <= (unit_cnt >= WORD_GAP_UNITS) ? ST_IDLE : ST_CHAR_SP;
               end else if (unit_cnt >= WORD_GAP_UNITS) begin
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign tok_pop = o_tok_valid && i_tok_ready;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_overflow <= 1'b0;
      end else if (push_req && fifo_full && !tok_pop) begin
         o_overflow <= 1'b1;
      end
   end

   morse_tok_fifo u_fifo (
      .clk       (i_clk),
      .rst_n     (i_rst_n),
      .push      (push_req),
      .push_data (push_tok),
      .full      (fifo_full),
      .pop_valid (o_tok_valid),
      .pop_data  (o_tok),
      .pop_ready (i_tok_ready)
   );

endmodule
